// File: rtl/frame_cap_pkg.sv
// Shared types and default frame geometry for the frame capture controller.
package frame_cap_pkg;

    // Default frame geometry: 640x480 fits in a 19-bit frame-buffer address.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_ADDR_W   = 19;

    // Width of a binarized pixel word.
    localparam int PIX_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_SYNC    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_HOLD    = 3'd4
    } cap_state_e;

endpackage

// File: rtl/frame_capture_ctrl_vsync_edge.sv
// vsync_edge: keeps one sample of pix_vsync history and decodes rise/fall
// pulses against the live input, so edges are seen on the same clk they occur.
module vsync_edge (
    input  logic clk,
    input  logic reset,
    input  logic pix_vsync,
    output logic vs_rise,
    output logic vs_fall
);

    logic vs_q;
    logic vs_d;

    // Next history sample is the current vsync level.
    always_comb begin
        vs_d = pix_vsync;
    end

    // History register; cleared to 0 so a frame in progress at reset looks like a rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) vs_q <= 1'b0;
        else        vs_q <= vs_d;
    end

    assign vs_rise = pix_vsync & ~vs_q;
    assign vs_fall = ~pix_vsync & vs_q;

endmodule

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: captures one whole binarized frame into a frame buffer
// on request and holds it until the recognizer releases it.
// Optional build macro CAP_TIMEOUT_EN adds a watchdog on SYNC/CAPTURE that
// aborts to IDLE with cap_err after TIMEOUT_CYC clks in either state.
module frame_capture_ctrl
    import frame_cap_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_vsync,
    input  logic              pix_clken,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              cap_req,
    input  logic              cap_rel,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              cap_busy,
    output logic              cap_done,
    output logic              cap_err,
    output logic [7:0]        frame_cnt
);

    localparam int PIX_N = H_ACTIVE * V_ACTIVE;
    // One extra bit so the count can hold PIX_N even when it equals 2^ADDR_W.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  PIX_TOTAL = CNT_W'(PIX_N);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = ADDR_W'(PIX_N - 1);

    cap_state_e         state_q, state_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]   wr_data_q, wr_data_d;
    logic               err_q, err_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   pix_idx_q, pix_idx_d;
    logic               vs_rise, vs_fall;

    vsync_edge u_vsync_edge (
        .clk       (clk),
        .reset     (reset),
        .pix_vsync (pix_vsync),
        .vs_rise   (vs_rise),
        .vs_fall   (vs_fall)
    );

`ifdef CAP_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    // Next-state, write-port and status computation.
    always_comb begin
        state_d     = state_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;
        pix_idx_d   = pix_idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cap_req) state_d = ST_ARM;
            end
            // Wait for the frame gap so a frame already running is skipped.
            ST_ARM: begin
                if (!pix_vsync) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (vs_rise) begin
                    state_d   = ST_CAPTURE;
                    pix_idx_d = '0;
                end
            end
            ST_CAPTURE: begin
                // A clken on the vsync falling clk is still part of the frame.
                if (pix_clken) begin
                    if (pix_idx_q < PIX_TOTAL) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = pix_idx_q[ADDR_W-1:0];
                        wr_data_d = pix_data;
                        pix_idx_d = pix_idx_q + 1'b1;
                    end else begin
                        err_d     = 1'b1;
                        wr_addr_d = ADDR_MAX;
                    end
                end
                if (vs_fall) begin
                    state_d     = ST_HOLD;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    if (pix_idx_d != PIX_TOTAL) err_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cap_rel) state_d = cap_req ? ST_ARM : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh arm starts with a clean error flag.
        if (state_d == ST_ARM && state_q != ST_ARM) err_d = 1'b0;

`ifdef CAP_TIMEOUT_EN
        tmo_d = '0;
        if (state_q == ST_SYNC || state_q == ST_CAPTURE) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_d == TMO_LIMIT) begin
                state_d     = ST_IDLE;
                wr_en_d     = 1'b0;
                wr_addr_d   = wr_addr_q;
                wr_data_d   = wr_data_q;
                err_d       = 1'b1;
                frame_cnt_d = frame_cnt_q;
            end
        end
        if (state_d != state_q) tmo_d = '0;
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            pix_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            pix_idx_q   <= pix_idx_d;
        end
    end

`ifdef CAP_TIMEOUT_EN
    // Watchdog counter of clks spent in the current SYNC/CAPTURE visit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`endif

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cap_err   = err_q;
    assign frame_cnt = frame_cnt_q;
    assign cap_busy  = (state_q == ST_ARM) || (state_q == ST_SYNC) || (state_q == ST_CAPTURE);
    assign cap_done  = (state_q == ST_HOLD);

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl with an 8x4 frame.
module tb_frame_capture_ctrl;

    localparam int H   = 8;
    localparam int V   = 4;
    localparam int N   = H * V;
    localparam int AW  = 5;
    localparam int TMO = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic          pix_vsync;
    logic          pix_clken;
    logic [11:0]   pix_data;
    logic          cap_req;
    logic          cap_rel;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          cap_busy;
    logic          cap_done;
    logic          cap_err;
    logic [7:0]    frame_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    frame_capture_ctrl #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .ADDR_W      (AW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_vsync (pix_vsync),
        .pix_clken (pix_clken),
        .pix_data  (pix_data),
        .cap_req   (cap_req),
        .cap_rel   (cap_rel),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cap_busy  (cap_busy),
        .cap_done  (cap_done),
        .cap_err   (cap_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [11:0] pix_val(input int i);
        return (i % 3 == 0) ? 12'hFFF : 12'h000;
    endfunction

    task automatic gap(input int n);
        pix_vsync = 1'b0;
        pix_clken = 1'b0;
        repeat (n) @(negedge clk);
        chk("gap_wr_en", wr_en, 0);
    endtask

    // One frame: rise, one blank clk, n pixels with a blank clk after every line.
    task automatic drive_frame(input int n, input bit cap, input int req_at,
                               input bit last_on_fall, input string tag);
        pix_vsync = 1'b1;
        pix_clken = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            pix_clken = 1'b1;
            pix_data  = pix_val(i);
            cap_req   = (i == req_at);
            if (last_on_fall && i == n - 1) pix_vsync = 1'b0;
            @(negedge clk);
            if (cap && i < N) begin
                chk({tag, "_wr_en"},   wr_en,   1);
                chk({tag, "_wr_addr"}, wr_addr, i);
                chk({tag, "_wr_data"}, wr_data, pix_val(i));
            end else begin
                chk({tag, "_wr_en_off"}, wr_en, 0);
                if (cap) chk({tag, "_addr_sat"}, wr_addr, N - 1);
            end
            if (i % H == H - 1 && i != n - 1) begin
                pix_clken = 1'b0;
                cap_req   = 1'b0;
                @(negedge clk);
                chk({tag, "_blank_wr_en"}, wr_en, 0);
            end
        end
        pix_clken = 1'b0;
        cap_req   = 1'b0;
        if (!last_on_fall) begin
            pix_vsync = 1'b0;
            @(negedge clk);
            chk({tag, "_fall_wr_en"}, wr_en, 0);
        end
    endtask

    task automatic request();
        pix_vsync = 1'b0;
        cap_req   = 1'b1;
        @(negedge clk);
        cap_req   = 1'b0;
        chk("req_busy", cap_busy, 1);
    endtask

    task automatic release_to_idle();
        cap_rel = 1'b1;
        cap_req = 1'b0;
        @(negedge clk);
        cap_rel = 1'b0;
        chk("rel_done", cap_done, 0);
        chk("rel_busy", cap_busy, 0);
    endtask

    initial begin
        int wcnt;
        reset     = 1'b0;
        pix_vsync = 1'b0;
        pix_clken = 1'b0;
        pix_data  = 12'h000;
        cap_req   = 1'b0;
        cap_rel   = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_wr_en",     wr_en,     0);
        chk("rst_wr_addr",   wr_addr,   0);
        chk("rst_wr_data",   wr_data,   0);
        chk("rst_busy",      cap_busy,  0);
        chk("rst_done",      cap_done,  0);
        chk("rst_err",       cap_err,   0);
        chk("rst_frame_cnt", frame_cnt, 0);
        reset = 1'b1;
        gap(2);

        // Nominal capture.
        request();
        gap(3);
        drive_frame(32, 1'b1, -1, 1'b0, "nom");
        chk("nom_done", cap_done, 1);
        chk("nom_busy", cap_busy, 0);
        chk("nom_err",  cap_err,  0);
        chk("nom_cnt",  frame_cnt, 1);
        release_to_idle();

        // Request mid-frame: that frame is skipped, the next is captured.
        // The last pixel lands on the vsync falling clk.
        drive_frame(32, 1'b0, 10, 1'b0, "mid_skip");
        chk("mid_busy", cap_busy, 1);
        chk("mid_cnt_held", frame_cnt, 1);
        gap(2);
        drive_frame(32, 1'b1, -1, 1'b1, "mid_cap");
        chk("mid_done", cap_done, 1);
        chk("mid_err",  cap_err,  0);
        chk("mid_cnt",  frame_cnt, 2);
        release_to_idle();

        // Short frame.
        request();
        gap(2);
        drive_frame(30, 1'b1, -1, 1'b0, "short");
        chk("short_done", cap_done, 1);
        chk("short_err",  cap_err,  1);
        chk("short_addr", wr_addr,  29);
        chk("short_cnt",  frame_cnt, 3);

        // Release with re-request goes straight to ARM.
        cap_rel = 1'b1;
        cap_req = 1'b1;
        @(negedge clk);
        cap_rel = 1'b0;
        cap_req = 1'b0;
        chk("rearm_busy", cap_busy, 1);
        chk("rearm_done", cap_done, 0);
        chk("rearm_err",  cap_err,  0);

        // Long frame; cap_req during CAPTURE is ignored.
        gap(2);
        drive_frame(34, 1'b1, 5, 1'b0, "long");
        chk("long_done", cap_done, 1);
        chk("long_err",  cap_err,  1);
        chk("long_addr", wr_addr,  31);
        chk("long_cnt",  frame_cnt, 4);
        release_to_idle();

        // Reset at pixel 16 of a capture.
        request();
        gap(2);
        pix_vsync = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            pix_clken = 1'b1;
            pix_data  = pix_val(i);
            @(negedge clk);
        end
        chk("prerst_wr_en",   wr_en,   1);
        chk("prerst_wr_addr", wr_addr, 15);
        pix_data = pix_val(16);
        reset    = 1'b0;
        #1;
        chk("arst_wr_en",     wr_en,     0);
        chk("arst_wr_addr",   wr_addr,   0);
        chk("arst_wr_data",   wr_data,   0);
        chk("arst_busy",      cap_busy,  0);
        chk("arst_done",      cap_done,  0);
        chk("arst_err",       cap_err,   0);
        chk("arst_frame_cnt", frame_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wcnt = 0;
        for (int c = 0; c < 80; c++) begin
            pix_vsync = (c % 40) < 30;
            pix_clken = pix_vsync;
            pix_data  = pix_val(c);
            @(negedge clk);
            if (wr_en) wcnt++;
        end
        chk("postrst_writes", wcnt, 0);
        chk("postrst_busy",   cap_busy, 0);

        // Watchdog in SYNC with vsync held low.
        pix_vsync = 1'b0;
        pix_clken = 1'b0;
        cap_req   = 1'b1;
        @(negedge clk);
        cap_req   = 1'b0;
        @(negedge clk);
        repeat (TMO - 1) @(negedge clk);
        chk("sync_busy_pre", cap_busy, 1);
        @(negedge clk);
`ifdef CAP_TIMEOUT_EN
        chk("tmo_busy",      cap_busy,  0);
        chk("tmo_done",      cap_done,  0);
        chk("tmo_err",       cap_err,   1);
        chk("tmo_frame_cnt", frame_cnt, 0);
`else
        repeat (50) @(negedge clk);
        chk("notmo_busy", cap_busy, 1);
        chk("notmo_err",  cap_err,  0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/frame_capture_ctrl.md
FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 Parameter ADDR_W, default 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
REQ-004 Parameter TIMEOUT_CYC, default 2000000, watchdog limit in clk cycles; used only with CAP_TIMEOUT_EN.
REQ-005 clk  input  1  single system clock; all logic on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 pix_vsync  input  1  high during the active frame and low in the frame gap; from the binarization pipeline.
REQ-008 pix_clken  input  1  pixel-valid strobe.
REQ-009 pix_data  input  12  binarized pixel, 12'hFFF or 12'h000.
REQ-010 cap_req  input  1  capture request from the recognizer; sampled only in IDLE and HOLD.
REQ-011 cap_rel  input  1  recognizer releases the held buffer.
REQ-012 wr_en  output  1  frame-buffer write enable.
REQ-013 wr_addr  output  ADDR_W  frame-buffer write address.
REQ-014 wr_data  output  12  frame-buffer write data.
REQ-015 cap_busy  output  1  high in ARM, SYNC and CAPTURE.
REQ-016 cap_done  output  1  high in HOLD only.
REQ-017 cap_err  output  1  sticky error; cleared on entry to ARM.
REQ-018 frame_cnt  output  8  count of completed captures; wraps 255->0.

Function
REQ-019 FSM states: IDLE, ARM, SYNC, CAPTURE, HOLD.
REQ-020 IDLE->ARM when cap_req=1.
REQ-021 ARM->SYNC when pix_vsync=0, so a frame already in progress is never captured partially.
REQ-022 SYNC->CAPTURE on the first clk where pix_vsync=1 and the previous sample was 0.
REQ-023 In CAPTURE, every pix_clken=1 with pix_vsync=1 produces, one clk later, wr_en=1, wr_data=pix_data and wr_addr=pixel index.
REQ-024 Pixel index starts at 0 for each frame and increments by 1 per write.
REQ-025 Outside CAPTURE, wr_en=0.
REQ-026 When the pixel index would exceed H_ACTIVE*V_ACTIVE-1, the write is suppressed, cap_err is set, and the address holds at its maximum.
REQ-027 CAPTURE->HOLD on the falling edge of pix_vsync.
REQ-028 On that transition, cap_err is set if the pixel count is not equal to H_ACTIVE*V_ACTIVE; frame_cnt increments.
REQ-029 A pix_clken on the same clk as the vsync falling edge is written, then the FSM exits CAPTURE.
REQ-030 HOLD->IDLE when cap_rel=1 and cap_req=0.
REQ-031 HOLD->ARM when cap_rel=1 and cap_req=1 on the same clk.
REQ-032 cap_req in ARM, SYNC or CAPTURE is ignored; cap_rel outside HOLD is ignored.
REQ-033 Latency from the pix_clken sample to wr_en: exactly 1 clk; no other buffering.

Reset
REQ-034 reset=0 asynchronously forces: state IDLE, wr_en=0, wr_addr=0, wr_data=0, cap_busy=0, cap_done=0, cap_err=0, frame_cnt=0, vsync history=0.
REQ-035 Reset asserted mid-CAPTURE aborts with no further writes; a new request is required after reset release.

Configuration
REQ-036 With CAP_TIMEOUT_EN defined, a cycle counter runs in SYNC and CAPTURE.
REQ-037 The counter clears on each state entry.
REQ-038 When the counter reaches TIMEOUT_CYC: cap_err is set, wr_en=0, and the FSM returns to IDLE without incrementing frame_cnt.
REQ-039 Without CAP_TIMEOUT_EN, no counter is synthesized and SYNC/CAPTURE wait indefinitely.

Structure
REQ-040 Package frame_cap_pkg holds the state enum type and the default frame constants (H_ACTIVE, V_ACTIVE, ADDR_W).
REQ-041 One sub-module, vsync_edge, registers pix_vsync and outputs rise and fall pulses; it is reset by the same reset.

Verification (H_ACTIVE=8, V_ACTIVE=4)
REQ-042 Nominal capture: cap_req pulse in IDLE, then gap, then a frame of 32 clken -> 32 writes at addr 0..31, one clk after each clken; cap_done=1, cap_err=0, frame_cnt=1.
REQ-043 Mid-frame request: cap_req at pixel 10 of a running frame -> no writes in that frame; the next full frame is captured at addr 0..31.
REQ-044 Short and long frames: 30 pixels -> HOLD with cap_err=1, last addr 29; 34 pixels -> 32 writes, addr stops at 31, cap_err=1.
REQ-045 Release with re-request: cap_rel=1 and cap_req=1 on the same clk in HOLD -> ARM next clk, cap_err cleared, cap_done=0, cap_busy=1.
REQ-046 Reset mid-capture: reset=0 at pixel 16 -> wr_en=0 immediately and all outputs at reset values; no writes until a new cap_req.
REQ-047 Timeout (CAP_TIMEOUT_EN, TIMEOUT_CYC=100): in SYNC, vsync held low 100 clks -> IDLE, cap_err=1, frame_cnt unchanged.
